count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Receive-side checker for the free-running up-counter: samples the counter's `count` bus every clock and checks it against the legal sequence 0,1,…,MAX_VALUE,0,…
- Reports MAX_VALUE arrivals, counts wraps and flags sequence violations with sticky status.
- Synthesizable, so the same block serves in simulation benches and in formal/silicon checking next to the counter.

Parameters:
- WIDTH, 4, width of the monitored count bus
- MAX_VALUE, 8, terminal count; legal range 0..MAX_VALUE, must be < 2**WIDTH
- WRAP_W, 8, width of the wrap counter
- STALL_LIMIT, 16, max consecutive hold cycles before a stall error (optional feature only)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  sampling enable; when 0, monitor ignores count_in and holds all state
- clr  input  1  synchronous clear of err/err_code/err_got/wrap_cnt; returns FSM to IDLE
- count_in  input  WIDTH  monitored counter value
- synced  output  1  high while FSM in TRACK
- max_pulse  output  1  one-cycle pulse: sample equal to MAX_VALUE accepted in TRACK
- wrap_cnt  output  WRAP_W  number of legal MAX_VALUE->0 transitions seen, saturating
- err  output  1  sticky error flag
- err_code  output  2  00 none, 01 bad step, 10 out of range, 11 stall
- err_got  output  WIDTH  count_in value that caused the first error

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including internal prev-value and hold counters.
- All outputs are registered. A sample taken at edge N affects outputs after edge N; no combinational input-to-output path.
- Each enabled cycle: s = count_in. p = previous accepted sample.
- IDLE:
  - s==0 -> TRACK, p=0.
  - Any other s -> stay in IDLE, no error (waits for alignment).
  - s>MAX_VALUE -> ERR, code 10.
- TRACK, legal transitions:
  - s==p: hold.
  - s==p+1 with p<MAX_VALUE: step.
  - p==MAX_VALUE and s==0: wrap; wrap_cnt+1, saturating at all-ones.
- TRACK, errors:
  - s>MAX_VALUE -> ERR, code 10. Range check has priority over step check.
  - Any other value -> ERR, code 01.
- TRACK, other rules:
  - max_pulse=1 on the cycle after s==MAX_VALUE is accepted via a step. Holds at MAX_VALUE do not re-pulse.
  - Step arithmetic: p+1 compared in WIDTH+1 bits; no wrap-around aliasing when MAX_VALUE=2**WIDTH-1.
- ERR:
  - err=1; err_code and err_got capture the first error only. Later samples are ignored.
  - Stays in ERR until clr or reset.
- clr has priority over the sample in the same cycle:
  - FSM->IDLE; err, err_code, err_got, wrap_cnt, max_pulse -> 0.
  - The sample in that cycle is discarded.
- en=0: no state change, max_pulse=0. A hold across disabled cycles is not a stall.
- reset mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: COUNT_MONITOR_STALL_EN.
- Defined:
  - Hold counter of width $clog2(STALL_LIMIT+1) increments on each enabled hold in TRACK and clears on step or wrap.
  - When a hold would make the counter exceed STALL_LIMIT -> ERR, code 11, err_got=s.
- Undefined:
  - Holds are unlimited; code 11 is never produced; no hold counter logic.

Decomposition:
- Package count_mon_pkg:
  - typedef enum state_e {IDLE, TRACK, ERR}
  - typedef enum logic [1:0] err_code_e {ERR_NONE, ERR_STEP, ERR_RANGE, ERR_STALL}
- Single module. The step/range classifier stays inline; no sub-module needed.

Test Plan:
- Reset then count_in 0..8,0..8,0 with en=1 -> synced=1 one cycle after first 0; max_pulse twice; wrap_cnt=2; err=0.
- In TRACK, count_in 3 then 5 -> err=1, err_code=01, err_got=5; subsequent 6,7 leave err_got=5.
- count_in 9 with MAX_VALUE=8, in IDLE or TRACK -> err_code=10, err_got=9.
- Count to 4, en=0 for 50 cycles, en=1 with 4,5 -> no error, wrap_cnt unchanged. With COUNT_MONITOR_STALL_EN: 17 enabled holds at 4 -> err_code=11.
- Error state then clr=1 with count_in=0 -> next cycle all outputs 0 and FSM in IDLE. Following 0 -> synced=1.
- Assert reset asynchronously mid-TRACK between clock edges -> outputs 0 immediately. Wrap counter saturation: WRAP_W=2, 5 wraps -> wrap_cnt=3.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared FSM state and error-code encodings for the count_monitor sequence checker.
package count_mon_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, ERR} state_e;

    typedef enum logic [1:0] {ERR_NONE, ERR_STEP, ERR_RANGE, ERR_STALL} err_code_e;

endpackage

// File: rtl/count_monitor.sv
// Receive-side checker for a free-running 0..MAX_VALUE up-counter with sticky error capture.
// Define COUNT_MONITOR_STALL_EN to flag holds longer than STALL_LIMIT enabled cycles.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_VALUE   = 8,
    parameter int WRAP_W      = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count_in,
    output logic              synced,
    output logic              max_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [WIDTH-1:0]  err_got
);

    if (MAX_VALUE >= (1 << WIDTH) || STALL_LIMIT < 1) begin : g_bad_params
        $error("count_monitor: MAX_VALUE must fit in WIDTH bits and STALL_LIMIT must be >= 1");
    end

    // Comparisons run one bit wider so p+1 cannot alias to 0 when MAX_VALUE is all-ones.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VALUE);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              max_pulse_q, max_pulse_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              err_q, err_d;
    err_code_e         code_q, code_d;
    logic [WIDTH-1:0]  got_q, got_d;

    logic [WIDTH:0]    s_ext, p_ext;
    logic              out_of_range, is_hold, is_step, is_wrap;
    logic              fault;
    err_code_e         fault_code;

    assign s_ext        = {1'b0, count_in};
    assign p_ext        = {1'b0, prev_q};
    assign out_of_range = s_ext > MAX_EXT;
    assign is_hold      = (count_in == prev_q);
    assign is_step      = (s_ext == p_ext + (WIDTH+1)'(1)) && (p_ext < MAX_EXT);
    assign is_wrap      = (p_ext == MAX_EXT) && (count_in == '0);

`ifdef COUNT_MONITOR_STALL_EN
    localparam int              HOLD_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [HOLD_W:0] LIMIT_EXT = (HOLD_W+1)'(STALL_LIMIT);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              stall;

    assign stall = ({1'b0, hold_q} + (HOLD_W+1)'(1)) > LIMIT_EXT;
`endif

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        max_pulse_d = 1'b0;
        wrap_d      = wrap_q;
        err_d       = err_q;
        code_d      = code_q;
        got_d       = got_q;
        fault       = 1'b0;
        fault_code  = ERR_NONE;
`ifdef COUNT_MONITOR_STALL_EN
        hold_d      = hold_q;
`endif
        if (clr) begin
            state_d = IDLE;
            prev_d  = '0;
            wrap_d  = '0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            got_d   = '0;
`ifdef COUNT_MONITOR_STALL_EN
            hold_d  = '0;
`endif
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (out_of_range) begin
                        fault      = 1'b1;
                        fault_code = ERR_RANGE;
                    end else if (count_in == '0) begin
                        state_d = TRACK;
                        prev_d  = '0;
`ifdef COUNT_MONITOR_STALL_EN
                        hold_d  = '0;
`endif
                    end
                end
                TRACK: begin
                    if (out_of_range) begin
                        fault      = 1'b1;
                        fault_code = ERR_RANGE;
                    end else if (is_hold) begin
`ifdef COUNT_MONITOR_STALL_EN
                        if (stall) begin
                            fault      = 1'b1;
                            fault_code = ERR_STALL;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
`endif
                    end else if (is_step) begin
                        prev_d      = count_in;
                        max_pulse_d = (s_ext == MAX_EXT);
`ifdef COUNT_MONITOR_STALL_EN
                        hold_d      = '0;
`endif
                    end else if (is_wrap) begin
                        prev_d = '0;
                        if (wrap_q != '1) wrap_d = wrap_q + WRAP_W'(1);
`ifdef COUNT_MONITOR_STALL_EN
                        hold_d = '0;
`endif
                    end else begin
                        fault      = 1'b1;
                        fault_code = ERR_STEP;
                    end
                end
                default: ;
            endcase
            // ERR is only reachable through a fault, so the first error is the one captured.
            if (fault) begin
                state_d = ERR;
                err_d   = 1'b1;
                code_d  = fault_code;
                got_d   = count_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            max_pulse_q <= 1'b0;
            wrap_q      <= '0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
            got_q       <= '0;
`ifdef COUNT_MONITOR_STALL_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            max_pulse_q <= max_pulse_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            code_q      <= code_d;
            got_q       <= got_d;
`ifdef COUNT_MONITOR_STALL_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign synced    = (state_q == TRACK);
    assign max_pulse = max_pulse_q;
    assign wrap_cnt  = wrap_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign err_got   = got_q;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_count_monitor;

    localparam int WIDTH  = 4;
    localparam int MAXV   = 8;
    localparam int WRAP_W = 8;
    localparam int STALL  = 16;

    logic              clk = 1'b0;
    logic              reset, en, clr;
    logic [WIDTH-1:0]  count_in;

    logic              a_synced, a_pulse, a_err;
    logic [WRAP_W-1:0] a_wrap;
    logic [1:0]        a_code;
    logic [WIDTH-1:0]  a_got;

    logic              b_synced, b_pulse, b_err;
    logic [1:0]        b_wrap;
    logic [1:0]        b_code;
    logic [WIDTH-1:0]  b_got;

    always #5 clk = ~clk;

    count_monitor #(.WIDTH(WIDTH), .MAX_VALUE(MAXV), .WRAP_W(WRAP_W), .STALL_LIMIT(STALL)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .count_in(count_in),
        .synced(a_synced), .max_pulse(a_pulse), .wrap_cnt(a_wrap),
        .err(a_err), .err_code(a_code), .err_got(a_got)
    );

    count_monitor #(.WIDTH(WIDTH), .MAX_VALUE(MAXV), .WRAP_W(2), .STALL_LIMIT(STALL)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .count_in(count_in),
        .synced(b_synced), .max_pulse(b_pulse), .wrap_cnt(b_wrap),
        .err(b_err), .err_code(b_code), .err_got(b_got)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain integers, wrap count kept unbounded and saturated on compare.
    bit m_sync, m_err, m_pulse;
    int m_prev, m_wraps, m_code, m_got, m_hold;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = 0; m_err = 0; m_pulse = 0;
        m_prev = 0; m_wraps = 0; m_code = 0; m_got = 0; m_hold = 0;
    endtask

    task automatic model_raise(int code, int s);
        m_err  = 1;
        m_sync = 0;
        m_code = code;
        m_got  = s;
    endtask

    task automatic model_step(bit e, bit c, int s);
        m_pulse = 0;
        if (c) begin
            m_sync = 0; m_err = 0; m_code = 0; m_got = 0; m_wraps = 0; m_hold = 0;
        end else if (e && !m_err) begin
            if (s > MAXV) model_raise(2, s);
            else if (!m_sync) begin
                if (s == 0) begin m_sync = 1; m_prev = 0; m_hold = 0; end
            end else if (s == m_prev) begin
`ifdef COUNT_MONITOR_STALL_EN
                if (m_hold + 1 > STALL) model_raise(3, s);
                else m_hold++;
`endif
            end else if (m_prev < MAXV && s == m_prev + 1) begin
                m_prev = s; m_hold = 0; m_pulse = (s == MAXV);
            end else if (m_prev == MAXV && s == 0) begin
                m_prev = 0; m_hold = 0; m_wraps++;
            end else model_raise(1, s);
        end
    endtask

    task automatic check_all();
        chk("synced",    32'(a_synced), 32'(m_sync));
        chk("max_pulse", 32'(a_pulse),  32'(m_pulse));
        chk("wrap_cnt",  32'(a_wrap),   (m_wraps > 255) ? 32'd255 : 32'(m_wraps));
        chk("err",       32'(a_err),    32'(m_err));
        chk("err_code",  32'(a_code),   32'(m_code));
        chk("err_got",   32'(a_got),    32'(m_got));
        chk("sat_wrap",  32'(b_wrap),   (m_wraps > 3) ? 32'd3 : 32'(m_wraps));
    endtask

    task automatic apply(bit e, bit c, int s);
        @(negedge clk);
        en       = e;
        clr      = c;
        count_in = s[WIDTH-1:0];
        @(posedge clk);
        model_step(e, c, s);
        #1;
        check_all();
    endtask

    int pulses;
    int exp_stall;

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; count_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Two full laps and a wrap back to 0
        pulses = 0;
        for (int lap = 0; lap < 2; lap++) begin
            for (int v = 0; v <= MAXV; v++) begin
                apply(1, 0, v);
                pulses += int'(a_pulse);
            end
        end
        apply(1, 0, 0);
        pulses += int'(a_pulse);
        chk("lap_pulses", 32'(pulses), 32'd2);
        chk("lap_wraps",  32'(a_wrap), 32'd2);

        // Bad step 3 -> 5, later samples must not overwrite the capture
        apply(1, 0, 1); apply(1, 0, 2); apply(1, 0, 3);
        apply(1, 0, 5); apply(1, 0, 6); apply(1, 0, 7);
        chk("step_got",  32'(a_got),  32'd5);
        chk("step_code", 32'(a_code), 32'd1);

        // clr with a 0 on the bus is discarded; the following 0 resyncs
        apply(1, 1, 0);
        chk("clr_synced", 32'(a_synced), 32'd0);
        apply(1, 0, 0);
        chk("resync", 32'(a_synced), 32'd1);

        // Out of range in IDLE, then in TRACK
        apply(1, 1, 0); apply(1, 0, 9);
        chk("range_idle", 32'(a_code), 32'd2);
        apply(1, 1, 0); apply(1, 0, 0); apply(1, 0, 9);
        chk("range_track", 32'(a_got), 32'd9);

        // Long disabled gap while holding 4 is not an error
        apply(1, 1, 0);
        for (int v = 0; v <= 4; v++) apply(1, 0, v);
        for (int i = 0; i < 50; i++) apply(0, 0, int'($urandom_range(15)));
        apply(1, 0, 4); apply(1, 0, 5);
        chk("gap_err", 32'(a_err), 32'd0);

        // 17 enabled holds at 4
        apply(1, 1, 0);
        for (int v = 0; v <= 4; v++) apply(1, 0, v);
        for (int i = 0; i < 17; i++) apply(1, 0, 4);
`ifdef COUNT_MONITOR_STALL_EN
        exp_stall = 3;
`else
        exp_stall = 0;
`endif
        chk("stall_code", 32'(a_code), 32'(exp_stall));

        // Five wraps saturate the 2-bit counter
        apply(1, 1, 0);
        for (int lap = 0; lap < 5; lap++)
            for (int v = 0; v <= MAXV; v++) apply(1, 0, v);
        apply(1, 0, 0);
        chk("sat_five", 32'(b_wrap), 32'd3);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic biased towards legal sequences
        for (int i = 0; i < 3000; i++) begin
            int r, k, s;
            bit e, c;
            r = int'($urandom_range(99));
            k = int'($urandom_range(99));
            c = (r < 3);
            e = (r >= 15) || c;
            if (k < 8)             s = int'($urandom_range(15));
            else if (!m_sync)      s = (k < 50) ? 0 : int'($urandom_range(MAXV));
            else if (k < 30)       s = m_prev;
            else                   s = (m_prev == MAXV) ? 0 : m_prev + 1;
            apply(e, c, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
